// File: rtl/sync_count_pkg.sv
// Shared constants and helpers for the sync_count_param up/down counter.
// Holds the default width, the derived default top count and the
// priority-ordered operation encoding used by the top-level next-state logic.
package sync_count_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // All-ones value for a given width. The 33-bit intermediate keeps width=32 exact.
  function automatic logic [31:0] max_count(input int unsigned width);
    logic [32:0] full;
    full = (33'd1 << width) - 33'd1;
    return full[31:0];
  endfunction

  localparam logic [31:0] DEFAULT_MAX = max_count(DEFAULT_WIDTH);

  // Per-edge operation. The encoding value matches the priority rank:
  // clear beats load, and load beats count.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  // Resolve the control inputs into the single winning operation.
  function automatic op_e decode_op(input logic clr, input logic ld, input logic inp);
    if (clr)      return OP_CLEAR;
    else if (ld)  return OP_LOAD;
    else if (inp) return OP_COUNT;
    else          return OP_HOLD;
  endfunction

endpackage

// File: rtl/sync_count_bit.sv
// One T-style counter slice: synchronous load has priority over toggle,
// and the asynchronous active-low reset clears the bit.
module sync_count_bit (
  input  logic ck,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  // Slice state: reset, else load, else toggle when enabled, else hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst)     q <= 1'b0;
    else if (ld)  q <= d;
    else if (t)   q <= ~q;
  end

endmodule

// File: rtl/sync_count_param.sv
// Parameterised up/down counter with synchronous clear and load, a
// combinational terminal-count flag and a registered carry-out pulse.
// Build option: define SYNC_COUNT_SAT_EN to saturate at the terminal value
// instead of wrapping; the default build wraps.
module sync_count_param
  import sync_count_pkg::*;
#(
  parameter int unsigned           WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      MAX   = WIDTH'(max_count(WIDTH))
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inp,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             co
);

  // Value taken when counting past the terminal in each direction.
`ifdef SYNC_COUNT_SAT_EN
  localparam logic [WIDTH-1:0] TERM_UP = MAX;
  localparam logic [WIDTH-1:0] TERM_DN = '0;
`else
  localparam logic [WIDTH-1:0] TERM_UP = '0;
  localparam logic [WIDTH-1:0] TERM_DN = MAX;
`endif

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] ld_clamped;
  logic [WIDTH-1:0] bit_d;
  logic [WIDTH-1:0] bit_t;
  logic             bit_ld;
  logic             term_event;
  op_e              op;

  assign out = count;

  // Terminal count follows the current value and direction with no register.
  assign tc = up ? (count == MAX) : (count == '0);

  // Next-state: pick the operation, compute the count step and turn it into
  // per-slice load/toggle controls.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op         = decode_op(clr, ld, inp);
    cnt_next   = count;
    ld_clamped = (ld_val > MAX) ? MAX : ld_val;
    bit_ld     = 1'b0;
    bit_d      = '0;
    bit_t      = '0;
    term_event = 1'b0;

    if (up) cnt_next = tc ? TERM_UP : count + WIDTH'(1);
    else    cnt_next = tc ? TERM_DN : count - WIDTH'(1);

    unique case (op)
      OP_CLEAR: begin
        bit_ld = 1'b1;
        bit_d  = '0;
      end
      OP_LOAD: begin
        bit_ld = 1'b1;
        bit_d  = ld_clamped;
      end
      OP_COUNT: begin
        // Toggle exactly the bits that differ; this also covers wrap to a
        // non-power-of-two MAX and saturation (no bits toggle).
        bit_t      = count ^ cnt_next;
        term_event = tc;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_count_bit u_bit (
      .ck (ck),
      .rst(rst),
      .ld (bit_ld),
      .d  (bit_d[i]),
      .t  (bit_t[i]),
      .q  (count[i])
    );
  end

  // Carry-out: one-cycle pulse after a counting edge taken at the terminal.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) co <= 1'b0;
    else      co <= term_event;
  end

endmodule

// File: tb/tb_sync_count_param.sv
// Directed bench for sync_count_param: a 4-bit full-range counter (MAX=15)
// and a 4-bit decade counter (MAX=9) share the same stimulus.
module tb_sync_count_param;

`ifdef SYNC_COUNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       rst;
  logic       clr, ld, inp, up;
  logic [3:0] ld_val;
  logic [3:0] out15, out9;
  logic       tc15, tc9, co15, co9;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  sync_count_param #(.WIDTH(4), .MAX(4'd15)) dut15 (
    .ck(ck), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
    .inp(inp), .up(up), .out(out15), .tc(tc15), .co(co15)
  );

  sync_count_param #(.WIDTH(4), .MAX(4'd9)) dut9 (
    .ck(ck), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
    .inp(inp), .up(up), .out(out9), .tc(tc9), .co(co9)
  );

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] ld_val;
    logic       inp;
    logic       up;
    logic [3:0] exp_out;
    logic       exp_tc;
    logic       exp_co;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic c, logic l, logic [3:0] lv, logic i, logic u,
                              logic [3:0] eo, logic et, logic ec);
    vec_t v;
    v.clr = c; v.ld = l; v.ld_val = lv; v.inp = i; v.up = u;
    v.exp_out = eo; v.exp_tc = et; v.exp_co = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic i, input logic u);
    clr = c; ld = l; ld_val = lv; inp = i; up = u;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    // Decade counter (MAX=9) table; each row is applied for one edge.
    vecs[0]  = mk(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b1, 1'b0);           // clear, tc while 0 and down
    vecs[1]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, SAT ? 4'd0 : 4'd9, SAT, 1'b1); // down from 0
    vecs[2]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, SAT ? 4'd0 : 4'd8, SAT, SAT);  // next step down
    vecs[3]  = mk(1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0);           // clr beats ld and inp
    vecs[4]  = mk(1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);           // load above MAX clamps
    vecs[5]  = mk(1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 4'd9, 1'b1, 1'b0);           // ld at terminal: no co
    vecs[6]  = mk(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd9, 1'b1, 1'b0);           // hold
    vecs[7]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, SAT ? 4'd9 : 4'd0, SAT, 1'b1); // up past 9
    vecs[8]  = mk(1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 4'd3, 1'b0, 1'b0);           // load 3
    vecs[9]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd4, 1'b0, 1'b0);           // flip direction each edge
    vecs[10] = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 1'b1, 1'b0);           // load 0, down: tc

    // Reset state, with tc following up combinationally.
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    #7;
    check("reset out15", out15, 0);
    check("reset co15", co15, 0);
    check("reset out9", out9, 0);
    check("reset co9", co9, 0);
    check("reset tc up", tc9, 0);
    up = 1'b0;
    #1;
    check("reset tc down", tc9, 1);

    // Full-range count from reset: 17 edges up.
    up  = 1'b1;
    inp = 1'b1;
    #4 rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("seq15 out k=%0d", k), out15,
            SAT ? ((k >= 15) ? 15 : k) : (k % 16));
      check($sformatf("seq15 co k=%0d", k), co15, SAT ? (k >= 16) : (k == 16));
      check($sformatf("seq15 tc k=%0d", k), tc15, SAT ? (k >= 15) : (k == 15));
    end

    // Table-driven checks on the decade counter.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].ld_val, vecs[i].inp, vecs[i].up);
      tick();
      check($sformatf("vec%0d out", i), out9, vecs[i].exp_out);
      check($sformatf("vec%0d tc", i), tc9, vecs[i].exp_tc);
      check($sformatf("vec%0d co", i), co9, vecs[i].exp_co);
    end

    // Terminal behaviour held for three counting edges, then reversed.
    drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    tick();
    check("term load out", out9, 9);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("term out k=%0d", k), out9, SAT ? 9 : k);
      check($sformatf("term co k=%0d", k), co9, SAT ? 1'b1 : (k == 0));
    end
    up = 1'b0;
    tick();
    check("term reverse out", out9, SAT ? 8 : 1);
    check("term reverse co", co9, 0);

    // Asynchronous reset mid-cycle while a co pulse is pending.
    drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    check("pre-reset co", co9, 1);
    #3 rst = 1'b0;
    #1;
    check("async reset out9", out9, 0);
    check("async reset co9", co9, 0);
    check("async reset out15", out15, 0);
    check("async reset co15", co15, 0);
    #2 rst = 1'b1;
    tick();
    check("post-reset out9", out9, 1);
    check("post-reset co9", co9, 0);
    check("post-reset out15", out15, 1);
    tick();
    check("post-reset out9 2", out9, 2);

    // Reset from a mid-range value (7) also clears immediately.
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    tick();
    check("load 7", out9, 7);
    inp = 1'b1;
    ld  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset from 7", out9, 0);
    #2 rst = 1'b1;
    tick();
    check("resume from 0", out9, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
